// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the AXI-style memory responder.
package axi_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_FETCH,
    RD_DATA
  } state_t;

  // Address shift for one full data beat (log2 of bytes per beat).
  function automatic int beat_shift(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/axi_mem_ram.sv
// Single-port RAM: per-byte write enables, registered read, no reset.
module axi_mem_ram #(
  parameter int DW = 256,
  parameter int AW = 10
) (
  input  logic            clk,
  input  logic            en,
  input  logic [DW/8-1:0] we,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    for (int b = 0; b < DW / 8; b++) begin
      if (we[b]) begin
        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI-style memory target on a shared address channel, backed by
// on-chip RAM; one burst outstanding at a time.
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 256,
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                    axi_clk,
  input  logic                    rst,
  input  logic [7:0]              aid,
  input  logic [ADDR_WIDTH-1:0]   aaddr,
  input  logic [7:0]              alen,
  input  logic [2:0]              asize,
  input  logic [1:0]              aburst,
  input  logic [1:0]              alock,
  input  logic                    atype,
  input  logic                    avalid,
  output logic                    aready,
  input  logic [7:0]              wid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [7:0]              bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [7:0]              rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready,
  output logic                    busy
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int SH = beat_shift(DATA_WIDTH);
  localparam int DL = MEM_DEPTH_LOG2;
  localparam logic [DL-1:0] IDX_ONE = 1;

  state_t state, state_n;

  logic [7:0]            id_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [DL-1:0]         idx_q;
  logic                  incr_q;
  logic                  err_q;
  logic                  aready_q;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  a_hs;
  logic                  w_hs;
  logic                  r_hs;
  logic                  last_beat;
  logic                  bad_req;
  logic                  ram_en;
  logic [NB-1:0]         ram_we;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  unused_ok;

  assign word_addr = aaddr >> SH;
  assign a_hs      = avalid & aready_q;
  assign w_hs      = wvalid & (state == WR_DATA);
  assign r_hs      = rready & (state == RD_DATA);
  assign last_beat = (cnt_q == len_q);
  assign bad_req   = !(aburst inside {BURST_FIXED, BURST_INCR})
                   || (asize != 3'(SH));
  assign unused_ok = ^{alock, wid, word_addr[ADDR_WIDTH-1:DL]};

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (a_hs) state_n = atype ? WR_DATA : RD_FETCH;
      WR_DATA:  if (w_hs && last_beat) state_n = WR_RESP;
      WR_RESP:  if (bready) state_n = IDLE;
      RD_FETCH: state_n = RD_DATA;
      RD_DATA:  if (rready) state_n = last_beat ? IDLE : RD_FETCH;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      aready_q <= 1'b0;
      id_q     <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      incr_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      aready_q <= (state_n == IDLE);
      if (a_hs) begin
        id_q   <= aid;
        len_q  <= alen;
        cnt_q  <= '0;
        idx_q  <= word_addr[DL-1:0];
        incr_q <= (aburst == BURST_INCR);
        err_q  <= bad_req;
      end
      if (w_hs) begin
        cnt_q <= cnt_q + 8'd1;
        if (incr_q) idx_q <= idx_q + IDX_ONE;
        // Burst length comes from alen; a misplaced wlast only flags it.
        if (wlast != last_beat) err_q <= 1'b1;
      end
      if (r_hs && !last_beat) begin
        cnt_q <= cnt_q + 8'd1;
        if (incr_q) idx_q <= idx_q + IDX_ONE;
      end
    end
  end

  assign ram_en = (state == RD_FETCH);
  assign ram_we = (w_hs && !err_q) ? wstrb : '0;

  axi_mem_ram #(
    .DW (DATA_WIDTH),
    .AW (DL)
  ) u_ram (
    .clk   (axi_clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (idx_q),
    .wdata (wdata),
    .rdata (ram_q)
  );

  assign aready = aready_q;
  assign wready = (state == WR_DATA);
  assign bvalid = (state == WR_RESP);
  assign bid    = bvalid ? id_q : '0;
  assign bresp  = (bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign rvalid = (state == RD_DATA);
  assign rid    = rvalid ? id_q : '0;
  assign rlast  = rvalid && last_beat;
  assign rresp  = (rvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign rdata  = (rvalid && !err_q) ? ram_q : '0;
  assign busy   = (state != IDLE);

endmodule
